// File: rtl/cv32e40p_div_lockstep_cmp_if.sv
// Result-stream interface for the divider lockstep comparator.
// Carries the accepted-result strobes and result values of the reference
// and unit-under-test divider instances.
//   RefVld_SI : reference result accepted this cycle
//   RefRes_DI : reference result value
//   UutVld_SI : UUT result accepted this cycle
//   UutRes_DI : UUT result value
// master drives the streams (divider side / bench), slave observes them
// (the comparator).
interface cv32e40p_div_lockstep_cmp_if #(
    parameter int C_WIDTH = 32
);
    logic               RefVld_SI;
    logic [C_WIDTH-1:0] RefRes_DI;
    logic               UutVld_SI;
    logic [C_WIDTH-1:0] UutRes_DI;

    modport master (output RefVld_SI, RefRes_DI, UutVld_SI, UutRes_DI);
    modport slave  (input  RefVld_SI, RefRes_DI, UutVld_SI, UutRes_DI);
endinterface

// File: rtl/cv32e40p_div_lockstep_cmp.sv
// Lockstep result comparator for the serial divider.
// Each result stream is buffered in its own FIFO so that the reference and
// UUT may run skewed by up to C_DEPTH results; heads are compared in order
// and problems are reported through sticky flags.
// Optional feature: define CV32E40P_LOCKSTEP_CAPTURE_EN to build the
// first-mismatch capture registers (ErrIdx_DO, ErrRef_DO, ErrUut_DO);
// without it those outputs are tied to 0.
// Ports:
//   Clk_CI      : clock, rising edge
//   Rst_RBI     : synchronous active-low reset
//   Clear_SI    : clears flags, counters and capture (not the FIFOs)
//   res_if      : reference/UUT result streams (slave modport)
//   Mismatch_SO : sticky, a compared pair differed
//   Overflow_SO : sticky, push dropped on a full FIFO
//   Timeout_SO  : sticky, one side waited C_TIMEOUT cycles
//   CmpCnt_DO   : saturating comparison count
//   ErrIdx_DO   : CmpCnt value at the first mismatch
//   ErrRef_DO / ErrUut_DO : first mismatching pair
module cv32e40p_div_lockstep_cmp #(
    parameter int C_WIDTH     = 32,
    parameter int C_DEPTH     = 4,
    parameter int C_TIMEOUT   = 64,
    parameter int C_CNT_WIDTH = 16
) (
    input  logic                       Clk_CI,
    input  logic                       Rst_RBI,
    input  logic                       Clear_SI,
    cv32e40p_div_lockstep_cmp_if.slave res_if,
    output logic                       Mismatch_SO,
    output logic                       Overflow_SO,
    output logic                       Timeout_SO,
    output logic [C_CNT_WIDTH-1:0]     CmpCnt_DO,
    output logic [C_CNT_WIDTH-1:0]     ErrIdx_DO,
    output logic [C_WIDTH-1:0]         ErrRef_DO,
    output logic [C_WIDTH-1:0]         ErrUut_DO
);
    localparam int PW = $clog2(C_DEPTH);
    localparam int TW = $clog2(C_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(C_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(C_TIMEOUT - 1);

    // Index 0 is the reference side, index 1 the UUT side.
    logic [C_WIDTH-1:0] mem  [2][C_DEPTH];
    logic [PW:0]        wptr [2];
    logic [PW:0]        rptr [2];
    logic [C_WIDTH-1:0] din  [2];
    logic [C_WIDTH-1:0] head [2];
    logic [1:0]         vld;
    logic [1:0]         empty;
    logic [1:0]         full;
    logic [1:0]         push;
    logic               cmp;
    logic               one_busy;
    logic               mismatch_set;
    logic               overflow_set;
    logic               timeout_set;
    logic [TW-1:0]      tmo_cnt;

    assign vld     = {res_if.UutVld_SI, res_if.RefVld_SI};
    assign din[0]  = res_if.RefRes_DI;
    assign din[1]  = res_if.UutRes_DI;

    // Full is detected by equal slot index with opposite wrap bit.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            empty[s] = (wptr[s] == rptr[s]);
            full[s]  = (wptr[s][PW] != rptr[s][PW]) &&
                       (wptr[s][PW-1:0] == rptr[s][PW-1:0]);
            head[s]  = mem[s][rptr[s][PW-1:0]];
        end
    end

    assign cmp          = ~|empty;
    assign one_busy     = empty[0] ^ empty[1];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push         = vld & (~full | {2{cmp}});
    assign overflow_set = |(vld & full & ~{2{cmp}});
    assign mismatch_set = cmp && (head[0] != head[1]);
    // Fires only on the transition to C_TIMEOUT so a clear is not undone
    // while the counter sits at its hold value.
    assign timeout_set  = one_busy && (tmo_cnt == TMO_LAST);

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            for (int s = 0; s < 2; s++) begin
                wptr[s] <= '0;
                rptr[s] <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) wptr[s] <= wptr[s] + 1'b1;
                if (cmp)     rptr[s] <= rptr[s] + 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge Clk_CI) begin
        for (int s = 0; s < 2; s++) begin
            if (Rst_RBI && push[s]) mem[s][wptr[s][PW-1:0]] <= din[s];
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            tmo_cnt <= '0;
        end else if (Clear_SI || cmp || !one_busy) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Sticky flags: a set condition wins over a coincident clear.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            Mismatch_SO <= 1'b0;
            Overflow_SO <= 1'b0;
            Timeout_SO  <= 1'b0;
            CmpCnt_DO   <= '0;
        end else begin
            if (mismatch_set)  Mismatch_SO <= 1'b1;
            else if (Clear_SI) Mismatch_SO <= 1'b0;
            if (overflow_set)  Overflow_SO <= 1'b1;
            else if (Clear_SI) Overflow_SO <= 1'b0;
            if (timeout_set)   Timeout_SO  <= 1'b1;
            else if (Clear_SI) Timeout_SO  <= 1'b0;
            if (Clear_SI)                     CmpCnt_DO <= '0;
            else if (cmp && CmpCnt_DO != '1)  CmpCnt_DO <= CmpCnt_DO + 1'b1;
        end
    end

`ifdef CV32E40P_LOCKSTEP_CAPTURE_EN
    logic capture;

    // A clear in the same cycle re-arms capture, so this mismatch counts as first.
    assign capture = mismatch_set && (!Mismatch_SO || Clear_SI);

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            ErrIdx_DO <= '0;
            ErrRef_DO <= '0;
            ErrUut_DO <= '0;
        end else if (capture) begin
            ErrIdx_DO <= CmpCnt_DO;
            ErrRef_DO <= head[0];
            ErrUut_DO <= head[1];
        end else if (Clear_SI) begin
            ErrIdx_DO <= '0;
            ErrRef_DO <= '0;
            ErrUut_DO <= '0;
        end
    end
`else
    assign ErrIdx_DO = '0;
    assign ErrRef_DO = '0;
    assign ErrUut_DO = '0;
`endif

endmodule
